// File: rtl/mesh_pkg.sv
// Packet layout, register map and helpers shared by the mesh NIC and its header formatter.
package mesh_pkg;

  localparam int PKT_W       = 64;
  localparam int VC_BIT      = 63;
  localparam int XDIR_BIT    = 62;
  localparam int YDIR_BIT    = 61;
  localparam int HOP_MSB     = 55;
  localparam int HOP_LSB     = 48;
  localparam int SRC_MSB     = 47;
  localparam int SRC_LSB     = 32;
  localparam int PAYLOAD_MSB = 31;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  typedef struct packed {
    logic        vc;
    logic        x_pos;
    logic        y_pos;
    logic [4:0]  rsvd;
    logic [3:0]  x_hops;
    logic [3:0]  y_hops;
    logic [7:0]  src_x;
    logic [7:0]  src_y;
    logic [31:0] payload;
  } pkt_t;

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mesh_nic_hdr_gen.sv
// Combinational routing-header builder: absolute destination -> direction bits, hop counts, source ID.
// Zero latency; no flow control of its own.
module mesh_nic_hdr_gen
  import mesh_pkg::*;
#(
  parameter int MY_X = 0,
  parameter int MY_Y = 0
) (
  input  logic        vc_in,
  input  logic [3:0]  dst_x,
  input  logic [3:0]  dst_y,
  input  logic [31:0] payload,
  output logic [63:0] pkt_dat
);

  logic [3:0] my_x;
  logic [3:0] my_y;

  assign my_x = 4'(MY_X);
  assign my_y = 4'(MY_Y);

  always_comb begin
    pkt_dat                    = '0;
    pkt_dat[VC_BIT]            = vc_in;
    pkt_dat[XDIR_BIT]          = (dst_x > my_x);
    pkt_dat[YDIR_BIT]          = (dst_y > my_y);
    pkt_dat[HOP_MSB -: 4]      = abs_diff(dst_x, my_x);
    pkt_dat[HOP_LSB +: 4]      = abs_diff(dst_y, my_y);
    pkt_dat[SRC_MSB:SRC_LSB]   = {8'(MY_X), 8'(MY_Y)};
    pkt_dat[PAYLOAD_MSB:0]     = payload;
  end

endmodule

// File: rtl/mesh_nic.sv
// Mesh NIC: one-deep in/out packet buffers behind a 4-register processor window; reads return next edge,
// inject no earlier than the cycle after a write. Full buffers drop processor writes / refuse router delivery.
// Header generation is built in when MESH_NIC_HDR_GEN_EN is defined; otherwise the written word is sent verbatim.
module mesh_nic
  import mesh_pkg::*;
#(
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int DW   = PKT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  input  logic          nicEn,
  input  logic          nicWrEn,
  input  logic          net_si,
  output logic          net_ri,
  input  logic [DW-1:0] net_di,
  output logic          net_so,
  input  logic          net_ro,
  output logic [DW-1:0] net_do,
  input  logic          net_polarity
);

  logic [DW-1:0] in_buf_q, in_buf_d;
  logic          in_full_q, in_full_d;
  pkt_t          out_buf_q, out_buf_d;
  logic          out_full_q, out_full_d;
  logic [DW-1:0] d_out_q, d_out_d;
  logic [DW-1:0] fmt_dat;
  logic          rd_en;
  logic          wr_en;

`ifdef MESH_NIC_HDR_GEN_EN
  mesh_nic_hdr_gen #(
    .MY_X (MY_X),
    .MY_Y (MY_Y)
  ) u_hdr_gen (
    .vc_in   (d_in[VC_BIT]),
    .dst_x   (d_in[HOP_MSB -: 4]),
    .dst_y   (d_in[HOP_LSB +: 4]),
    .payload (d_in[PAYLOAD_MSB:0]),
    .pkt_dat (fmt_dat)
  );
`else
  assign fmt_dat = d_in;
`endif

  assign rd_en  = nicEn & ~nicWrEn;
  assign wr_en  = nicEn & nicWrEn;
  assign net_ri = ~in_full_q;
  // Packets only leave on the mesh phase matching their virtual channel.
  assign net_so = out_full_q & (out_buf_q.vc == net_polarity);
  assign net_do = out_buf_q;
  assign d_out  = d_out_q;

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    d_out_d    = d_out_q;

    if (rd_en) begin
      case (addr)
        ADDR_IN_BUF: begin
          d_out_d   = in_buf_q;
          in_full_d = 1'b0;
        end
        ADDR_IN_STAT:  d_out_d = {{(DW-1){1'b0}}, in_full_q};
        ADDR_OUT_BUF:  d_out_d = '0;
        default:       d_out_d = {{(DW-1){1'b0}}, out_full_q};
      endcase
    end

    // Capture after the read-clear so a delivery on the same edge is never lost.
    if (net_si && net_ri) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    if (net_so && net_ro) begin
      out_full_d = 1'b0;
    end

    if (wr_en && (addr == ADDR_OUT_BUF) && !out_full_q) begin
      out_buf_d  = pkt_t'(fmt_dat);
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      d_out_q    <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
    end
  end

endmodule

// File: tb/tb_mesh_nic.sv
// Scoreboarded bench for mesh_nic: directed scenarios plus random traffic against a transaction-level model.
// Follows MESH_NIC_HDR_GEN_EN so the same bench covers both builds.
module tb_mesh_nic;

  localparam int MYX = 1;
  localparam int MYY = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;

  always #5 clk = ~clk;

  mesh_nic #(.MY_X(MYX), .MY_Y(MYY), .DW(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  int n_chk = 0;
  int n_err = 0;

  // Expected responses: read data, per-cycle {ri, so, do}, injected packets.
  logic [63:0] rd_q[$];
  logic [65:0] cyc_q[$];
  logic [63:0] inj_q[$];
  logic        chk_en = 1'b0;
  logic        rd_pend = 1'b0;

  // Model state: what the processor and router should observe.
  logic        m_in_full = 1'b0;
  logic [63:0] m_in_buf = '0;
  logic        m_out_full = 1'b0;
  logic [63:0] m_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fmt(input logic [63:0] w);
`ifdef MESH_NIC_HDR_GEN_EN
    int dx;
    int dy;
    logic [63:0] r;
    dx = int'(w[55:52]);
    dy = int'(w[51:48]);
    r = '0;
    r[63] = w[63];
    r[62] = (dx > MYX);
    r[61] = (dy > MYY);
    r[55:52] = 4'((dx > MYX) ? dx - MYX : MYX - dx);
    r[51:48] = 4'((dy > MYY) ? dy - MYY : MYY - dy);
    r[47:40] = 8'(MYX);
    r[39:32] = 8'(MYY);
    r[31:0] = w[31:0];
    return r;
`else
    return w;
`endif
  endfunction

  // One clock of stimulus; called just after a rising edge, returns just after the next one.
  task automatic cyc(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                     input logic si, input logic [63:0] di, input logic ro, input logic pol);
    logic cap, inj, so, wacc, rd00;
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    so   = m_out_full && (m_out[63] == pol);
    cap  = si && !m_in_full;
    inj  = so && ro;
    wacc = en && wr && (a == 2'd2) && !m_out_full;
    rd00 = en && !wr && (a == 2'd0);
    cyc_q.push_back({!m_in_full, so, m_out});
    if (inj) inj_q.push_back(m_out);
    if (en && !wr) begin
      case (a)
        2'd0: rd_q.push_back(m_in_buf);
        2'd1: rd_q.push_back({63'd0, m_in_full});
        2'd2: rd_q.push_back(64'd0);
        default: rd_q.push_back({63'd0, m_out_full});
      endcase
    end
    @(posedge clk); #1;
    if (rd00) m_in_full = 1'b0;
    if (cap) begin m_in_buf = di; m_in_full = 1'b1; end
    if (inj) m_out_full = 1'b0;
    if (wacc) begin m_out = fmt(din); m_out_full = 1'b1; end
  endtask

  task automatic idle(input logic ro, input logic pol);
    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, ro, pol);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b0, a, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic wr_out(input logic [63:0] w, input logic ro, input logic pol);
    cyc(1'b1, 1'b1, 2'd2, w, 1'b0, 64'd0, ro, pol);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rd_q.delete(); cyc_q.delete(); inj_q.delete();
    reset = 1'b0;
    net_si = 1'b1; net_di = {$urandom(), $urandom()};
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = {$urandom(), $urandom()};
    net_ro = 1'b1; net_polarity = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0; net_ro = 1'b0; net_polarity = 1'b0;
    m_in_full = 1'b0; m_in_buf = '0; m_out_full = 1'b0; m_out = '0;
    chk("rst_d_out", d_out, 64'd0);
    chk("rst_net_so", {63'd0, net_so}, 64'd0);
    chk("rst_net_ri", {63'd0, net_ri}, 64'd1);
    chk("rst_net_do", net_do, 64'd0);
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [65:0] e;
    logic [63:0] x;
    if (!chk_en) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rd_underflow: got d_out %h with no read expected", d_out);
        end else begin
          x = rd_q.pop_front();
          chk("d_out", d_out, x);
        end
      end
      rd_pend = nicEn && !nicWrEn && reset;
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        chk("net_ri", {63'd0, net_ri}, {63'd0, e[65]});
        chk("net_so", {63'd0, net_so}, {63'd0, e[64]});
        if (e[64]) chk("net_do", net_do, e[63:0]);
      end
      if (net_so && net_ro) begin
        if (inj_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL inj_unexpected: got %h expected no injection", net_do);
        end else begin
          x = inj_q.pop_front();
          chk("inj_dat", net_do, x);
        end
      end
    end
  end

  initial begin
    logic [63:0] w;
    logic [63:0] exp_h;
    logic en, wr, si, ro, pol;
    logic [1:0] a;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("por_d_out", d_out, 64'd0);
    chk("por_net_ri", {63'd0, net_ri}, 64'd1);
    chk_en = 1'b1;

    // Reset with pending traffic in both directions
    wr_out(64'h8000_0000_0000_00AA, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    do_reset();
    rd(2'd1);
    rd(2'd3);
    rd(2'd0);
    idle(1'b0, 1'b0);

    // Header formatting and drain
    w = {1'b1, 2'b00, 5'b0, 8'h22, 16'h0, 32'hAAAA_AAAA};
`ifdef MESH_NIC_HDR_GEN_EN
    exp_h = 64'hE011_0101_AAAA_AAAA;
`else
    exp_h = 64'h8022_0000_AAAA_AAAA;
`endif
    wr_out(w, 1'b1, 1'b1);
    chk("hdr_net_do", net_do, exp_h);
    idle(1'b1, 1'b1);
    rd(2'd3);
    idle(1'b0, 1'b0);

    // Verbatim word (identity when header generation is off)
    w = 64'h0123_4567_89AB_CDEF;
    wr_out(w, 1'b0, 1'b0);
    chk("word_net_do", net_do, fmt(w));
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);

    // Polarity gating: vc=0 waits through polarity=1
    wr_out(64'h0000_0000_0000_0042, 1'b1, 1'b1);
    repeat (3) idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Backpressure; the second write is dropped
    wr_out(64'h8000_0000_0000_0077, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    wr_out(64'h1234, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    rd(2'd3);
    idle(1'b0, 1'b0);

    // Input path: second delivery refused while full
    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
    rd(2'd1);
    rd(2'd0);
    rd(2'd1);
    rd(2'd2);
    rd(2'd0);
    idle(1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      en  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      a   = 2'($urandom_range(0, 3));
      si  = 1'($urandom_range(0, 1));
      ro  = 1'($urandom_range(0, 1));
      pol = 1'($urandom_range(0, 1));
      if (en && !wr && a == 2'd0 && !m_in_full) si = 1'b0;
      cyc(en, wr, a, {$urandom(), $urandom()}, si, {$urandom(), $urandom()}, ro, pol);
    end
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    chk("inj_left", 64'(inj_q.size()), 64'd0);
    chk("rd_left", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
